// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module  : serial_arith_pkg
// Purpose : Shared FSM encodings, default width and counter sizing for the
//           bit-serial arithmetic blocks.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Bits needed to count 0..width-1, never less than one.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module  : full_subtractor
// Purpose : Single-bit combinational full subtractor (a - b - borrow_in).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial LSB-first unsigned subtractor with start/busy/done.
//           Optional signed overflow output: SERIAL_SUBTRACTOR_OVERFLOW_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             wire_clk,
  input  logic             wire_rst,
  input  logic             wire_start,
  input  logic [WIDTH-1:0] wire_a,
  input  logic [WIDTH-1:0] wire_b,
  output logic             wire_busy,
  output logic             wire_done,
  output logic [WIDTH-1:0] wire_diff,
  output logic             wire_borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             wire_overflow
`endif
);

  localparam int CW = count_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] d_sr;
  logic             bor_ff;
  logic [CW-1:0]    count;
  logic             d_bit, bor_next;
  logic [WIDTH-1:0] d_full;
  logic             load, last_step;

  full_subtractor u_fs (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (bor_ff),
    .diff       (d_bit),
    .borrow_out (bor_next)
  );

  // Partial result with this step's bit placed at the MSB.
  assign d_full    = {d_bit, d_sr};
  assign load      = wire_start && ((state == S_IDLE) || (state == S_DONE));
  assign last_step = (state == S_SHIFT) && (count == CW'(WIDTH - 1));

  always_ff @(posedge wire_clk) begin
    if (wire_rst) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    wire_busy  = 1'b0;
    wire_done  = 1'b0;
    case (state)
      S_IDLE:  if (wire_start) state_next = S_SHIFT;
      S_SHIFT: begin
        wire_busy = 1'b1;
        if (last_step) state_next = S_DONE;
      end
      S_DONE: begin
        wire_done  = 1'b1;
        state_next = wire_start ? S_SHIFT : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wire_clk) begin
    if (wire_rst) begin
      a_sr        <= '0;
      b_sr        <= '0;
      d_sr        <= '0;
      bor_ff      <= 1'b0;
      count       <= '0;
      wire_diff   <= '0;
      wire_borrow <= 1'b0;
    end else if (load) begin
      a_sr   <= wire_a;
      b_sr   <= wire_b;
      d_sr   <= '0;
      bor_ff <= 1'b0;
      count  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      d_sr   <= d_full[WIDTH-1:1];
      bor_ff <= bor_next;
      count  <= count + 1'b1;
      if (last_step) begin
        wire_diff   <= d_full;
        wire_borrow <= bor_next;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb, b_msb;

  // Operand MSBs are shifted out early, so keep a copy for the overflow test.
  always_ff @(posedge wire_clk) begin
    if (wire_rst) begin
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      wire_overflow <= 1'b0;
    end else if (load) begin
      a_msb <= wire_a[WIDTH-1];
      b_msb <= wire_b[WIDTH-1];
    end else if (last_step) begin
      wire_overflow <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first unsigned subtractor computing wire_a - wire_b over WIDTH clock cycles.
- Built from a single-bit full-subtractor stage, a borrow flip-flop, operand shift registers and a small FSM.
- Counterpart to the combinational adder cells in the arithmetic library; provides area-cheap subtraction for multi-cycle datapaths.
- Uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
wire_clk  input  1  clock; all state changes on its rising edge
wire_rst  input  1  reset; synchronous, active-high
wire_start  input  1  request; sampled only when the block is idle or done
wire_a  input  WIDTH  minuend; captured on the accepted start edge
wire_b  input  WIDTH  subtrahend; captured on the accepted start edge
wire_busy  output  1  high while the subtraction is in progress
wire_done  output  1  one-cycle pulse; result valid
wire_diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next completion
wire_borrow  output  1  final borrow out (1 when a < b unsigned); held with wire_diff

Behaviour:
- Reset (wire_rst=1 at an edge):
  - State goes to IDLE.
  - wire_busy=0, wire_done=0, wire_diff=0, wire_borrow=0.
  - Bit counter, shift registers and borrow flip-flop are all cleared.
  - Reset applied mid-operation aborts the operation with no done pulse, and the previous result is cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on wire_start=1, load the A and B shift registers, borrow_ff=0 and count=0, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: wire_busy=1. Each edge does one bit step:
    - a0/b0 are the operand LSBs; d = a0^b0^bor; bor_next = (~a0&b0) | (~(a0^b0)&bor).
    - d shifts into the MSB of the internal diff register; the A and B registers shift right; borrow_ff <= bor_next; count increments.
    - On the edge where count==WIDTH-1: update wire_diff with the completed word including this step's bit, update wire_borrow with bor_next, and go to DONE.
  - DONE: wire_done=1 and wire_busy=0 for exactly one cycle.
    - If wire_start=1 in this cycle, it is accepted (back-to-back): operands load and the FSM goes to SHIFT.
    - Otherwise the FSM goes to IDLE.
- Latency:
  - Start is accepted at edge E.
  - wire_done is high from edge E+WIDTH to E+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- wire_start during SHIFT is ignored, and operand inputs are not re-sampled.
- wire_diff and wire_borrow change only at completion or reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH. a==b gives diff=0, borrow=0. 0-1 gives all ones, borrow=1.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_OVERFLOW_EN.
- When defined:
  - Adds output wire_overflow (1 bit), the signed two's-complement overflow, updated together with wire_diff.
  - overflow = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - Reset value is 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the FSM state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2);
  - the default WIDTH constant;
  - the counter-width helper (clog2 of WIDTH).
- One natural sub-module, full_subtractor (combinational): inputs a, b, borrow_in; outputs diff, borrow_out. It is instantiated once for the per-bit step.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 8 cycles; done pulses 8 edges after acceptance; diff=0x02, borrow=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1. Also a=0x00, b=0x01 -> diff=0xFF, borrow=1. Also a=0x5A, b=0x5A -> diff=0x00, borrow=0.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. Then a=0x10, b=0x01 -> overflow=0.
- Start a=0x09, b=0x04; in cycle 3, pulse start with a=0xFF, b=0x00 -> second request ignored; result diff=0x05, single done pulse.
- Start a=0x20, b=0x10 and hold start high through DONE with new a=0x07, b=0x02 -> first done gives 0x10; second operation begins immediately; second done 9 cycles later gives 0x05.
- Complete 0x05-0x03, start a new op, assert wire_rst in cycle 4 -> next edge busy=0, done=0, diff=0, borrow=0; no done pulse follows; a fresh start afterward computes correctly.
